zaxxon_wave_player: RTL and testbench

ZAXXON_WAVE_PLAYER -- requirements
Module: zaxxon_wave_player

---
 rtl/zaxxon_wave_pkg.sv | 22 ++
 rtl/zaxxon_wave_mix.sv | 40 ++++
 rtl/zaxxon_wave_player.sv | 182 ++++++++++++++++++
 tb/tb_zaxxon_wave_player.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/zaxxon_wave_pkg.sv
// Shared constants for the Zaxxon sample player: channel count, the per-channel
// sample table in SDRAM word addresses, and the fetch sequencer states.
package zaxxon_wave_pkg;

  localparam int NUM_CH   = 4;
  localparam int ADDR_W   = 20;
  localparam int SAMPLE_W = 16;

  // END is exclusive; channel 1 is deliberately a 3-word sound.
  localparam logic [NUM_CH-1:0][ADDR_W-1:0] CH_START =
    {20'h00400, 20'h00300, 20'h00200, 20'h00100};
  localparam logic [NUM_CH-1:0][ADDR_W-1:0] CH_END =
    {20'h00480, 20'h00340, 20'h00203, 20'h00180};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_NEXT
  } fetch_state_t;

endpackage

// File: rtl/zaxxon_wave_mix.sv
// Four-channel mixer: each sample is attenuated by 4 (arithmetic) and summed;
// the 16-bit sum cannot overflow, so no saturation stage is needed.
module zaxxon_wave_mix
  import zaxxon_wave_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic                             clk_sys,
  input  logic                             rst_n,
  input  logic [NUM_CH-1:0][DATA_W-1:0]    sample_p0,
  input  logic                             vld_p0,
  output logic signed [DATA_W-1:0]         mix_p1,
  output logic                             vld_p1
);

  function automatic logic signed [DATA_W-1:0] quarter(input logic signed [DATA_W-1:0] s);
    return s >>> 2;
  endfunction

  logic signed [DATA_W-1:0] sum_p0;

  always_comb begin
    sum_p0 = '0;
    for (int n = 0; n < NUM_CH; n++) begin
      sum_p0 = sum_p0 + quarter($signed(sample_p0[n]));
    end
  end

  // p0 -> p1
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      mix_p1 <= '0;
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= vld_p0;
      if (vld_p0) mix_p1 <= sum_p0;
    end
  end

endmodule

// File: rtl/zaxxon_wave_player.sv
// Four-channel SDRAM sample player: on every output tick it walks the channels,
// fetches one word per busy channel and hands the latched samples to the mixer.
module zaxxon_wave_player
  import zaxxon_wave_pkg::*;
#(
  parameter int RD_LATENCY = 8,
  parameter int TICK_DIV   = 2176
) (
  input  logic                        clock_24,
  input  logic                        reset_n,
  input  logic [NUM_CH-1:0]           trig,
  input  logic [NUM_CH-1:0]           loop_en,
  output logic [ADDR_W-1:0]           wave_addr,
  output logic                        wave_rd,
  input  logic signed [SAMPLE_W-1:0]  wave_data,
  output logic [NUM_CH-1:0]           busy,
  output logic signed [SAMPLE_W-1:0]  audio_out,
  output logic                        sample_strobe
);

  localparam int TW = $clog2(TICK_DIV);
  localparam int LW = $clog2(RD_LATENCY + 1);

  // Assert asynchronously, release two clocks after reset_n rises.
  logic [1:0] rst_sync;
  logic       rst_n_s;

  always_ff @(posedge clock_24 or negedge reset_n) begin
    if (!reset_n) rst_sync <= '0;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n_s = rst_sync[1];

  logic [TW-1:0] tick_cnt;
  logic          tick;

  assign tick = (tick_cnt == TW'(TICK_DIV - 1));

  always_ff @(posedge clock_24 or negedge rst_n_s) begin
    if (!rst_n_s)  tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else           tick_cnt <= tick_cnt + TW'(1);
  end

  // edge_en holds off detection for one cycle so a trigger already high at
  // reset release is captured as history rather than seen as an edge.
  logic [NUM_CH-1:0] trig_hist;
  logic              edge_en;
  logic [NUM_CH-1:0] rise;

  assign rise = trig & ~trig_hist & {NUM_CH{edge_en}};

  always_ff @(posedge clock_24 or negedge rst_n_s) begin
    if (!rst_n_s) begin
      trig_hist <= '0;
      edge_en   <= 1'b0;
    end else begin
      trig_hist <= trig;
      edge_en   <= 1'b1;
    end
  end

  fetch_state_t      state, state_nx;
  logic [1:0]        ch, ch_nx;
  logic [LW-1:0]     wait_cnt;
  logic              wait_done;
  logic              mix_req;
  logic              issue_rd;

  assign wait_done = (wait_cnt == LW'(RD_LATENCY - 1));

  always_comb begin
    state_nx = state;
    ch_nx    = ch;
    mix_req  = 1'b0;
    issue_rd = 1'b0;
    case (state)
      ST_IDLE: begin
        if (tick) begin
          ch_nx    = 2'd0;
          state_nx = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        issue_rd = busy[ch];
        state_nx = busy[ch] ? ST_WAIT : ST_NEXT;
      end
      ST_WAIT: begin
        if (wait_done) state_nx = ST_NEXT;
      end
      ST_NEXT: begin
        if (ch == 2'(NUM_CH - 1)) begin
          state_nx = ST_IDLE;
          mix_req  = 1'b1;
        end else begin
          ch_nx    = ch + 2'd1;
          state_nx = ST_ISSUE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock_24 or negedge rst_n_s) begin
    if (!rst_n_s) begin
      state    <= ST_IDLE;
      ch       <= 2'd0;
      wait_cnt <= '0;
    end else begin
      state    <= state_nx;
      ch       <= ch_nx;
      wait_cnt <= (state == ST_WAIT) ? wait_cnt + LW'(1) : '0;
    end
  end

  logic [ADDR_W-1:0]                 addr_hold;
  logic [NUM_CH-1:0][ADDR_W-1:0]     ptr;
  logic [NUM_CH-1:0][SAMPLE_W-1:0]   sample;
  logic [NUM_CH-1:0]                 fresh;
  logic [ADDR_W-1:0]                 ptr_inc;

  assign wave_rd   = issue_rd;
  assign wave_addr = issue_rd ? ptr[ch] : addr_hold;
  assign ptr_inc   = ptr[ch] + ADDR_W'(1);

  always_ff @(posedge clock_24 or negedge rst_n_s) begin
    if (!rst_n_s) addr_hold <= '0;
    else if (issue_rd) addr_hold <= ptr[ch];
  end

  // fresh marks a channel restarted since its last read, so the pending
  // NEXT leaves the pointer at START instead of stepping past it.
  always_ff @(posedge clock_24 or negedge rst_n_s) begin
    if (!rst_n_s) begin
      busy   <= '0;
      ptr    <= '0;
      sample <= '0;
      fresh  <= '0;
    end else begin
      case (state)
        ST_ISSUE: begin
          fresh[ch] <= 1'b0;
          if (!busy[ch]) sample[ch] <= '0;
        end
        ST_WAIT: begin
          if (wait_done) sample[ch] <= wave_data;
        end
        ST_NEXT: begin
          fresh[ch] <= 1'b0;
          if (busy[ch] && !fresh[ch]) begin
            ptr[ch] <= ptr_inc;
            if (ptr_inc == CH_END[ch]) begin
              if (loop_en[ch]) ptr[ch]  <= CH_START[ch];
              else             busy[ch] <= 1'b0;
            end
          end
        end
        default: ;
      endcase
      for (int n = 0; n < NUM_CH; n++) begin
        if (rise[n]) begin
          busy[n]   <= 1'b1;
          ptr[n]    <= CH_START[n];
          sample[n] <= '0;
          fresh[n]  <= 1'b1;
        end
      end
    end
  end

  zaxxon_wave_mix #(
    .DATA_W (SAMPLE_W)
  ) u_mix (
    .clk_sys   (clock_24),
    .rst_n     (rst_n_s),
    .sample_p0 (sample),
    .vld_p0    (mix_req),
    .mix_p1    (audio_out),
    .vld_p1    (sample_strobe)
  );

endmodule

// File: tb/tb_zaxxon_wave_player.sv
// Bench for zaxxon_wave_player: an SDRAM responder with fixed read latency and a
// per-tick channel model that predicts read addresses, busy flags and the mix.
module tb_zaxxon_wave_player;
  import zaxxon_wave_pkg::*;

  localparam int RD_LAT = 8;
  localparam int TDIV   = 64;
  localparam int TMO    = 3 * TDIV;

  logic        clock_24 = 1'b0;
  logic        reset_n  = 1'b0;
  logic [3:0]  trig     = '0;
  logic [3:0]  loop_en  = '0;
  logic [19:0] wave_addr;
  logic        wave_rd;
  logic [15:0] wave_data = 16'hDEAD;
  logic [3:0]  busy;
  logic [15:0] audio_out;
  logic        sample_strobe;

  int tests = 0;
  int fails = 0;

  zaxxon_wave_player #(.RD_LATENCY(RD_LAT), .TICK_DIV(TDIV)) dut (
    .clock_24      (clock_24),
    .reset_n       (reset_n),
    .trig          (trig),
    .loop_en       (loop_en),
    .wave_addr     (wave_addr),
    .wave_rd       (wave_rd),
    .wave_data     (wave_data),
    .busy          (busy),
    .audio_out     (audio_out),
    .sample_strobe (sample_strobe)
  );

  always #5 clock_24 = ~clock_24;

  // SDRAM content: selectable constant patterns or an address hash.
  int          data_mode = 0;
  logic [15:0] seed = 16'h1234;

  function automatic logic [15:0] data_of(input logic [19:0] a);
    case (data_mode)
      1:       return 16'h7FFF;
      2:       return 16'h8000;
      3:       return 16'h4000;
      default: return 16'(a * 20'h09E37) ^ seed;
    endcase
  endfunction

  // Responder: data valid only in the cycle RD_LAT after the read pulse.
  int          pend = 0;
  logic [19:0] pend_addr = '0;
  logic [19:0] rd_q[$];

  always @(negedge clock_24) begin
    if (wave_rd) begin
      pend      = RD_LAT;
      pend_addr = wave_addr;
      rd_q.push_back(wave_addr);
      wave_data = 16'($urandom);
    end else if (pend > 0) begin
      pend--;
      wave_data = (pend == 0) ? data_of(pend_addr) : 16'($urandom);
    end else begin
      wave_data = 16'($urandom);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model, one entry per channel.
  logic [3:0]  m_busy;
  logic [19:0] m_ptr[4];
  logic [15:0] m_samp[4];

  task automatic model_clear();
    m_busy = '0;
    for (int n = 0; n < 4; n++) begin
      m_ptr[n]  = '0;
      m_samp[n] = '0;
    end
  endtask

  task automatic model_trig(input logic [3:0] m);
    for (int n = 0; n < 4; n++) begin
      if (m[n]) begin
        m_busy[n] = 1'b1;
        m_ptr[n]  = CH_START[n];
        m_samp[n] = '0;
      end
    end
  endtask

  function automatic int floor_quarter(input int v);
    return (v >= 0) ? v / 4 : -((-v + 3) / 4);
  endfunction

  // Advance the model by one tick; returns the expected reads and mix value.
  logic [19:0] exp_q[$];
  logic [15:0] exp_aud;

  task automatic model_step();
    int acc;
    exp_q.delete();
    acc = 0;
    for (int n = 0; n < 4; n++) begin
      if (m_busy[n]) begin
        exp_q.push_back(m_ptr[n]);
        m_samp[n] = data_of(m_ptr[n]);
        m_ptr[n]  = m_ptr[n] + 20'd1;
        if (m_ptr[n] == CH_END[n]) begin
          if (loop_en[n]) m_ptr[n]  = CH_START[n];
          else            m_busy[n] = 1'b0;
        end
      end else begin
        m_samp[n] = '0;
      end
      acc += floor_quarter(int'($signed(m_samp[n])));
    end
    exp_aud = 16'(acc);
  endtask

  logic [15:0] obs_aud;
  logic [19:0] first_rd, last_rd;

  task automatic wait_strobe(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clock_24);
      n++;
    end while (!sample_strobe && n < TMO);
    check({tag, "_strobe"}, {31'd0, sample_strobe}, 32'd1);
    obs_aud = audio_out;
  endtask

  task automatic observe(input string tag);
    wait_strobe(tag);
    check({tag, "_audio"}, {16'd0, obs_aud}, {16'd0, exp_aud});
    check({tag, "_busy"}, {28'd0, busy}, {28'd0, m_busy});
    check({tag, "_nreads"}, rd_q.size(), exp_q.size());
    first_rd = (rd_q.size() > 0) ? rd_q[0] : 20'hFFFFF;
    last_rd  = (rd_q.size() > 0) ? rd_q[rd_q.size()-1] : 20'hFFFFF;
    for (int i = 0; i < exp_q.size() && i < rd_q.size(); i++)
      check({tag, "_addr"}, {12'd0, rd_q[i]}, {12'd0, exp_q[i]});
    rd_q.delete();
  endtask

  task automatic run_seq(input string tag);
    model_step();
    observe(tag);
  endtask

  task automatic pulse_trig(input logic [3:0] m);
    @(negedge clock_24);
    trig = m;
    @(negedge clock_24);
    trig = '0;
  endtask

  task automatic start(input logic [3:0] m);
    pulse_trig(m);
    model_trig(m);
  endtask

  task automatic wait_rd(input string tag, input logic [19:0] a);
    int  n;
    bit  ok;
    n  = 0;
    ok = 1'b0;
    while (n < TMO && !ok) begin
      @(negedge clock_24);
      n++;
      if (wave_rd && wave_addr == a) ok = 1'b1;
    end
    check({tag, "_rd_seen"}, {31'd0, ok}, 32'd1);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clock_24);
    reset_n = 1'b0;
    trig    = '0;
    repeat (3) @(negedge clock_24);
    reset_n = 1'b1;
    model_clear();
    wait_strobe(tag);
    check({tag, "_sync_audio"}, {16'd0, obs_aud}, 32'd0);
    rd_q.delete();
  endtask

  initial begin
    assert (4 * (RD_LAT + 2) + 2 < TDIV)
      else $fatal(1, "FAIL constraint 4*(RD_LATENCY+2)+2 < TICK_DIV");
    model_clear();

    // Reset state
    repeat (3) @(negedge clock_24);
    #1;
    check("rst_busy", {28'd0, busy}, 32'd0);
    check("rst_rd", {31'd0, wave_rd}, 32'd0);
    check("rst_addr", {12'd0, wave_addr}, 32'd0);
    check("rst_audio", {16'd0, audio_out}, 32'd0);
    check("rst_strobe", {31'd0, sample_strobe}, 32'd0);
    reset_n = 1'b1;
    wait_strobe("boot");
    check("boot_audio", {16'd0, obs_aud}, 32'd0);
    rd_q.delete();

    // Single channel, first read and attenuated mix
    data_mode = 3;
    loop_en   = 4'h0;
    start(4'b0001);
    run_seq("ch0_first");
    check("ch0_first_addr", {12'd0, first_rd}, 32'h00100);
    check("ch0_first_mix", {16'd0, obs_aud}, 32'h1000);

    // Three-word sound without loop
    do_reset("len3");
    data_mode = 0;
    seed      = 16'($urandom);
    start(4'b0010);
    for (int i = 0; i < 4; i++) run_seq("len3");
    check("len3_busy_fell", {31'd0, busy[1]}, 32'd0);
    check("len3_4th_mix", {16'd0, obs_aud}, 32'd0);

    // Same sound looping
    do_reset("loop");
    loop_en = 4'b0010;
    start(4'b0010);
    for (int i = 0; i < 4; i++) run_seq("loop");
    check("loop_4th_addr", {12'd0, last_rd}, 32'h00200);

    // Full-scale mixes
    do_reset("full");
    loop_en   = 4'hF;
    data_mode = 1;
    start(4'hF);
    run_seq("full_pos");
    check("full_pos_mix", {16'd0, obs_aud}, 32'h7FFC);
    data_mode = 2;
    run_seq("full_neg");
    check("full_neg_mix", {16'd0, obs_aud}, 32'h8000);

    // Retrigger channel 2 while its read is outstanding
    do_reset("retrig");
    loop_en   = 4'h0;
    data_mode = 0;
    start(4'b0100);
    run_seq("retrig_a");
    model_step();
    wait_rd("retrig", 20'h00301);
    start(4'b0100);
    observe("retrig_b");
    run_seq("retrig_c");
    check("retrig_addr", {12'd0, first_rd}, 32'h00300);

    // Reset in the middle of a read, trigger held through release
    do_reset("midrst");
    data_mode = 3;
    start(4'b0001);
    run_seq("midrst_a");
    wait_rd("midrst", 20'h00101);
    repeat (3) @(negedge clock_24);
    reset_n = 1'b0;
    trig    = 4'hF;
    #1;
    check("midrst_rd", {31'd0, wave_rd}, 32'd0);
    check("midrst_busy", {28'd0, busy}, 32'd0);
    check("midrst_audio", {16'd0, audio_out}, 32'd0);
    repeat (3) @(negedge clock_24);
    reset_n = 1'b1;
    repeat (6) @(negedge clock_24);
    trig = '0;
    check("held_trig_busy", {28'd0, busy}, 32'd0);
    model_clear();
    rd_q.delete();
    run_seq("midrst_after");

    // Randomised triggers, loop enables and sample data
    for (int it = 0; it < 10; it++) begin
      logic [3:0] m;
      m         = 4'($urandom_range(0, 15));
      loop_en   = 4'($urandom);
      data_mode = 0;
      seed      = 16'($urandom);
      if (m != 4'h0) start(m);
      run_seq("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
